// File: rtl/linreg_sequencer.sv
// rtl/linreg_sequencer.sv - sequential linear-regression predictor with one shared 16x16 multiplier
module linreg_sequencer (
    input  logic        clk,
    input  logic        r0,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        start,
    input  logic [7:0]  n_param,
    input  logic [15:0] features,
    input  logic        feat_valid,
    output logic        feat_ready,
    output logic [31:0] predict,
    output logic        r,
    input  logic        ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] predict_q, predict_d;
    logic        err_q, err_d;
    logic [31:0] bias_q, bias_d;
    logic [15:0] w_q [8];
    logic [15:0] w_d [8];

    logic [31:0] prod;
    logic [31:0] acc_next;
    logic        accept;
    logic        last_feat;

    // Shared multiplier: current weight times incoming feature, summed mod 2^32
    always_comb begin
        prod      = {16'b0, w_q[idx_q[2:0]]} * {16'b0, features};
        acc_next  = acc_q + prod;
        accept    = (state_q == MAC) && feat_valid;
        last_feat = (idx_q + 4'd1) == cnt_q;
    end

    // State register
    always_ff @(posedge clk or negedge r0) begin
        if (!r0) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_param == 8'd0) begin
                        state_d = DONE;
                    end else if (n_param <= 8'd8) begin
                        state_d = MAC;
                    end
                end
            end
            MAC: begin
                if (accept && last_feat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and configuration next values; a same-cycle config write is
    // committed but the request still reads the pre-write registers
    always_comb begin
        acc_d     = acc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        predict_d = predict_q;
        err_d     = 1'b0;
        bias_d    = bias_q;
        w_d       = w_q;
        if (state_q == IDLE) begin
            if (start) begin
                if (n_param == 8'd0) begin
                    predict_d = bias_q;
                end else if (n_param <= 8'd8) begin
                    acc_d = bias_q;
                    idx_d = 4'd0;
                    cnt_d = n_param[3:0];
                end else begin
                    err_d = 1'b1;
                end
            end
            if (cfg_we) begin
                if (cfg_addr == 4'd0) begin
                    bias_d = cfg_data;
                end else if (cfg_addr <= 4'd8) begin
                    w_d[cfg_addr[2:0] - 3'd1] = cfg_data[15:0];
                end
            end
        end
        if (accept) begin
            acc_d = acc_next;
            idx_d = idx_q + 4'd1;
            if (last_feat) begin
                predict_d = acc_next;
            end
        end
    end

    // Datapath and configuration registers; reset restores default coefficients
    always_ff @(posedge clk or negedge r0) begin
        if (!r0) begin
            acc_q     <= 32'd0;
            idx_q     <= 4'd0;
            cnt_q     <= 4'd0;
            predict_q <= 32'd0;
            err_q     <= 1'b0;
            bias_q    <= 32'd10000;
            w_q[0]    <= 16'd5000;
            for (int i = 1; i < 8; i++) begin
                w_q[i] <= 16'd0;
            end
        end else begin
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            predict_q <= predict_d;
            err_q     <= err_d;
            bias_q    <= bias_d;
            w_q       <= w_d;
        end
    end

    // Outputs decoded from state and registered datapath
    always_comb begin
        feat_ready = (state_q == MAC);
        r          = (state_q == DONE);
        busy       = (state_q != IDLE);
        err        = err_q;
        predict    = predict_q;
    end

endmodule

// File: tb/tb_linreg_sequencer.sv
// tb/tb_linreg_sequencer.sv - directed self-checking bench for linreg_sequencer
module tb_linreg_sequencer;

    logic        clk = 1'b0;
    logic        r0;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        start;
    logic [7:0]  n_param;
    logic [15:0] features;
    logic        feat_valid;
    logic        feat_ready;
    logic [31:0] predict;
    logic        r;
    logic        ack;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    linreg_sequencer dut (
        .clk        (clk),
        .r0         (r0),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .n_param    (n_param),
        .features   (features),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .predict    (predict),
        .r          (r),
        .ack        (ack),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r0 = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 32'd0;
        start = 1'b0; n_param = 8'd0; features = 16'd0; feat_valid = 1'b0; ack = 1'b0;
        tick(); tick();
        n_checks++; if (predict !== 32'd0) begin n_fail++; $display("FAIL reset_predict: got %0d want 0", predict); end
        n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL reset_r: got %b want 0", r); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (feat_ready !== 1'b0) begin n_fail++; $display("FAIL reset_feat_ready: got %b want 0", feat_ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        r0 = 1'b1;
    endtask

    task automatic test_single();
        start = 1'b1; n_param = 8'd1;
        tick();
        start = 1'b0;
        n_checks++; if (feat_ready !== 1'b1) begin n_fail++; $display("FAIL single_feat_ready: got %b want 1", feat_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL single_r_early: got %b want 0", r); end
        features = 16'd250; feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        n_checks++; if (feat_ready !== 1'b0) begin n_fail++; $display("FAIL single_feat_ready_done: got %b want 0", feat_ready); end
        n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL single_r: got %b want 1", r); end
        n_checks++; if (predict !== 32'd1260000) begin n_fail++; $display("FAIL single_predict: got %0d want 1260000", predict); end
        tick();
        n_checks++; if (r !== 1'b1 || predict !== 32'd1260000) begin n_fail++; $display("FAIL single_hold: got r=%b p=%0d want r=1 p=1260000", r, predict); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++; if (r !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_ack: got r=%b busy=%b want 0 0", r, busy); end
    endtask

    task automatic test_zero();
        start = 1'b1; n_param = 8'd0;
        tick();
        start = 1'b0;
        n_checks++; if (r !== 1'b1 || predict !== 32'd10000) begin n_fail++; $display("FAIL zero_result: got r=%b p=%0d want r=1 p=10000", r, predict); end
        n_checks++; if (feat_ready !== 1'b0) begin n_fail++; $display("FAIL zero_feat_ready: got %b want 0", feat_ready); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++; if (r !== 1'b0 || feat_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ack: got r=%b fr=%b want 0 0", r, feat_ready); end
    endtask

    task automatic test_stall();
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 32'd3;
        tick();
        cfg_we = 1'b0;
        start = 1'b1; n_param = 8'd2;
        tick();
        start = 1'b0;
        features = 16'd250; feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0; features = 16'd9999;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (feat_ready !== 1'b1 || r !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: got fr=%b r=%b want 1 0", i, feat_ready, r); end
            tick();
        end
        features = 16'd4; feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        n_checks++; if (r !== 1'b1 || predict !== 32'd1260012) begin n_fail++; $display("FAIL stall_result: got r=%b p=%0d want r=1 p=1260012", r, predict); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL stall_ack: got %b want 0", r); end
    endtask

    task automatic test_err();
        start = 1'b1; n_param = 8'd9;
        tick();
        start = 1'b0;
        n_checks++; if (err !== 1'b1 || busy !== 1'b0 || r !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got err=%b busy=%b r=%b want 1 0 0", err, busy, r); end
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_width: got %b want 0", err); end
        n_checks++; if (predict !== 32'd1260012) begin n_fail++; $display("FAIL err_predict_kept: got %0d want 1260012", predict); end
        start = 1'b1; n_param = 8'd1;
        tick();
        start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 32'd7;
        features = 16'd250; feat_valid = 1'b1;
        tick();
        cfg_we = 1'b0; feat_valid = 1'b0;
        n_checks++; if (predict !== 32'd1260000) begin n_fail++; $display("FAIL busy_cfg_cur: got %0d want 1260000", predict); end
        ack = 1'b1; start = 1'b1; n_param = 8'd0;
        tick();
        ack = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0 || r !== 1'b0) begin n_fail++; $display("FAIL start_in_done: got busy=%b r=%b want 0 0", busy, r); end
        start = 1'b1; n_param = 8'd1;
        tick();
        start = 1'b0;
        features = 16'd250; feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        n_checks++; if (predict !== 32'd1260000) begin n_fail++; $display("FAIL busy_cfg_next: got %0d want 1260000", predict); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_wrap();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 32'hFFFFFFFF;
        tick();
        cfg_addr = 4'd1; cfg_data = 32'd1;
        tick();
        cfg_addr = 4'd9; cfg_data = 32'd77;
        tick();
        cfg_we = 1'b0;
        start = 1'b1; n_param = 8'd1;
        tick();
        start = 1'b0;
        features = 16'd1; feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        n_checks++; if (predict !== 32'd0 || r !== 1'b1) begin n_fail++; $display("FAIL wrap: got r=%b p=%0d want r=1 p=0", r, predict); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 32'd100; start = 1'b1; n_param = 8'd0;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        n_checks++; if (predict !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL cfg_start_old: got %h want ffffffff", predict); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        start = 1'b1; n_param = 8'd0;
        tick();
        start = 1'b0;
        n_checks++; if (predict !== 32'd100) begin n_fail++; $display("FAIL cfg_start_new: got %0d want 100", predict); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; n_param = 8'd3;
        tick();
        start = 1'b0;
        features = 16'd250; feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        n_checks++; if (feat_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_mac: got %b want 1", feat_ready); end
        r0 = 1'b0;
        #1;
        n_checks++; if (feat_ready !== 1'b0 || busy !== 1'b0 || r !== 1'b0 || err !== 1'b0 || predict !== 32'd0) begin
            n_fail++; $display("FAIL mid_async: got fr=%b busy=%b r=%b err=%b p=%0d want all 0", feat_ready, busy, r, err, predict);
        end
        tick();
        r0 = 1'b1;
        start = 1'b1; n_param = 8'd1;
        tick();
        start = 1'b0;
        n_checks++; if (feat_ready !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got %b want 1", feat_ready); end
        features = 16'd250; feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        n_checks++; if (r !== 1'b1 || predict !== 32'd1260000) begin n_fail++; $display("FAIL mid_result: got r=%b p=%0d want r=1 p=1260000", r, predict); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_stall();
        test_err();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
